// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: single-port memory shared by fetch and data ports with stall arbitration
module unified_mem_arbiter #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DATA_BASE   = 128,
    parameter int MAX_IF_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              base_we,
    input  logic [ADDR_W-1:0] base_wdata,
    output logic [ADDR_W-1:0] base_q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [3:0]        wait_cnt;
    logic              starved, if_gnt, d_gnt, d_rd, d_wr;
    logic [ADDR_W-1:0] ea;
    // data normally wins a conflict; fetch wins once it has lost MAX_IF_WAIT in a row
    always_comb begin
        starved  = wait_cnt == 4'(MAX_IF_WAIT);
        if_gnt   = if_req & (~d_req | starved);
        d_gnt    = d_req & ~if_gnt;
        d_rd     = d_gnt & ~d_we;
        d_wr     = d_gnt & d_we;
        ea       = d_addr + base_q;
        if_stall = if_req & ~if_gnt;
        d_stall  = d_req & ~d_gnt;
    end
    // array storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (d_wr) mem[ea] <= d_wdata;
    end
    // registered read ports, base register and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_data  <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            base_q   <= ADDR_W'(DATA_BASE);
            wait_cnt <= '0;
        end else begin
            if_valid <= if_gnt;
            d_valid  <= d_rd;
            if (if_gnt) if_data <= mem[if_addr];
            if (d_rd) d_rdata <= mem[ea];
            if (base_we) base_q <= base_wdata;
            if (if_gnt) wait_cnt <= '0;
            else if (if_req && !starved) wait_cnt <= wait_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table-driven vectors with a read-result scoreboard
module tb_unified_mem_arbiter;
    typedef struct {
        logic       ir;
        logic [7:0] ia;
        logic       dr, dw;
        logic [7:0] da, dd;
        logic       bw;
        logic [7:0] bd;
        logic       eis, eds;
    } vec_t;
    typedef struct {
        logic       known;
        logic [7:0] data;
    } exp_t;

    logic clk = 0, rst = 1;
    logic if_req = 0, d_req = 0, d_we = 0, base_we = 0;
    logic [7:0] if_addr = 0, d_addr = 0, d_wdata = 0, base_wdata = 0;
    logic if_stall, if_valid, d_stall, d_valid;
    logic [7:0] if_data, d_rdata, base_q;

    int checks = 0, failures = 0, gap = 0, max_gap = 0;
    logic [7:0] mdl_mem [256];
    bit mdl_known [256];
    logic [7:0] mdl_base = 8'd128;
    exp_t if_q[$], d_q[$];
    vec_t tbl[$];

    unified_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_data(if_data), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_stall(d_stall),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .base_we(base_we), .base_wdata(base_wdata), .base_q(base_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                                input logic [7:0] da, input logic [7:0] dd, input logic bw,
                                input logic [7:0] bd, input logic eis, input logic eds);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.bw = bw; v.bd = bd; v.eis = eis; v.eds = eds;
        return v;
    endfunction

    task automatic step(input vec_t v);
        logic gi, gd;
        logic [7:0] ea;
        exp_t e;
        @(negedge clk);
        if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dw; d_addr = v.da;
        d_wdata = v.dd; base_we = v.bw; base_wdata = v.bd;
        #1;
        chk("if_stall", 32'(if_stall), 32'(v.eis));
        chk("d_stall", 32'(d_stall), 32'(v.eds));
        gi = v.ir & ~v.eis;
        gd = v.dr & ~v.eds;
        ea = v.da + mdl_base;
        if (gi) if_q.push_back('{mdl_known[v.ia], mdl_mem[v.ia]});
        if (gd && !v.dw) d_q.push_back('{mdl_known[ea], mdl_mem[ea]});
        @(posedge clk);
        if (gd && v.dw) begin
            mdl_mem[ea] = v.dd;
            mdl_known[ea] = 1'b1;
        end
        if (v.bw) mdl_base = v.bd;
        #1;
        if (if_q.size() > 0) begin
            e = if_q.pop_front();
            chk("if_valid", 32'(if_valid), 32'd1);
            if (e.known) chk("if_data", 32'(if_data), 32'(e.data));
        end else chk("if_valid", 32'(if_valid), 32'd0);
        if (d_q.size() > 0) begin
            e = d_q.pop_front();
            chk("d_valid", 32'(d_valid), 32'd1);
            if (e.known) chk("d_rdata", 32'(d_rdata), 32'(e.data));
        end else chk("d_valid", 32'(d_valid), 32'd0);
        chk("base_q", 32'(base_q), 32'(mdl_base));
        gap = if_valid ? 0 : gap + 1;
        if (gap > max_gap) max_gap = gap;
    endtask

    initial begin
        // relocation, ignored d_we, first conflict window
        tbl.push_back(mk(0, 0,   1, 1, 5, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 0, 5, 0,     0, 0, 0, 0));
        tbl.push_back(mk(1, 133, 0, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 1, 5, 8'hFF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   1, 0, 5, 0,     0, 0, 0, 0));
        tbl.push_back(mk(1, 133, 1, 0, 5, 0,     0, 0, 1, 0));
        tbl.push_back(mk(1, 133, 1, 0, 5, 0,     0, 0, 1, 0));
        tbl.push_back(mk(1, 133, 1, 0, 5, 0,     0, 0, 1, 0));
        tbl.push_back(mk(1, 133, 1, 0, 5, 0,     0, 0, 0, 1));
        // same-cycle base write uses the old base
        tbl.push_back(mk(0, 0,   0, 0, 0, 0,     1, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 1, 5, 8'h5A, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,   0, 0, 0, 0,     1, 128,   0, 0));
        tbl.push_back(mk(0, 0,   1, 0, 5, 0,     1, 0,     0, 0));
        tbl.push_back(mk(0, 0,   1, 0, 5, 0,     0, 0,     0, 0));
        // address wrap
        tbl.push_back(mk(0, 0,     0, 0, 0,     0,     1, 8'hF0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 1, 8'h20, 8'h3C, 0, 0,     0, 0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 0,     0,     0, 0,     0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_base_q", 32'(base_q), 32'd128);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_if_data", 32'(if_data), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) step(tbl[i]);

        max_gap = 0;
        gap = 0;
        for (int i = 0; i < 12; i++)
            step(mk(1, 133, 1, 0, 5, 0, 0, 0, (i % 4) != 3, (i % 4) == 3));
        chk("if_gap_bound", 32'(max_gap < 4), 32'd1);

        // asynchronous reset with a granted read pending
        @(negedge clk);
        if_req = 0; d_req = 1; d_we = 0; d_addr = 5; base_we = 0;
        #1;
        chk("pre_rst_d_stall", 32'(d_stall), 32'd0);
        #1;
        rst = 1;
        #1;
        chk("async_base_q", 32'(base_q), 32'd128);
        chk("async_if_valid", 32'(if_valid), 32'd0);
        chk("async_d_valid", 32'(d_valid), 32'd0);
        chk("async_if_data", 32'(if_data), 32'd0);
        chk("async_d_rdata", 32'(d_rdata), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        d_req = 0;
        mdl_base = 8'd128;
        if_q.delete();
        d_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_d_valid", 32'(d_valid), 32'd0);
            chk("post_rst_if_valid", 32'(if_valid), 32'd0);
            chk("post_rst_d_rdata", 32'(d_rdata), 32'd0);
            chk("post_rst_if_data", 32'(if_data), 32'd0);
        end
        step(mk(0, 0, 1, 0, 5, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
